// File: rtl/cfu_initiator_pkg.sv
// Shared types and constants for the CFU initiator: FSM state encoding,
// CFU function identifiers and datapath widths.
package cfu_initiator_pkg;

    localparam int unsigned FID_W  = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned TMO_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam logic [FID_W-1:0] CFU_SET_OFFSET = 3'b000;
    localparam logic [FID_W-1:0] CFU_SET_ACC    = 3'b001;
    localparam logic [FID_W-1:0] CFU_MACC4      = 3'b010;
    localparam logic [FID_W-1:0] CFU_READ       = 3'b011;

    // True while a command is in flight (being offered or awaiting its response).
    function automatic logic is_active(input state_e s);
        return (s == ST_ISSUE) || (s == ST_WAIT);
    endfunction

endpackage

// File: rtl/cfu_initiator.sv
// CFU initiator: accepts one upstream request, issues it to a CFU over a
// valid/ready command channel, collects the response (or aborts on timeout)
// and presents the result upstream. Exactly one command is outstanding.
// All handshake outputs are decoded from the state register only, so a
// purely combinational CFU can be attached without forming a loop.
module cfu_initiator
    import cfu_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [FID_W-1:0]  req_function_id,
    input  logic [DATA_W-1:0] req_inputs_0,
    input  logic [DATA_W-1:0] req_inputs_1,

    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [FID_W-1:0]  cmd_payload_function_id,
    output logic [DATA_W-1:0] cmd_payload_inputs_0,
    output logic [DATA_W-1:0] cmd_payload_inputs_1,

    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic              rsp_payload_response_ok,
    input  logic [DATA_W-1:0] rsp_payload_outputs_0,

    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_ok,
    output logic              res_timeout,

    output logic              busy,
    output logic [CNT_W-1:0]  done_count
);

    state_e              state_r;
    state_e              state_nxt_s;

    logic [FID_W-1:0]    fid_r;
    logic [DATA_W-1:0]   in0_r;
    logic [DATA_W-1:0]   in1_r;

    logic [DATA_W-1:0]   res_data_r;
    logic                res_ok_r;
    logic                res_timeout_r;
    logic [CNT_W-1:0]    done_count_r;
    logic [TMO_W-1:0]    tmo_cnt_r;

    logic                req_ready_s;
    logic                cmd_valid_s;
    logic                rsp_ready_s;
    logic                res_valid_s;
    logic                busy_s;

    logic                req_take_s;
    logic                capture_s;
    logic                tmo_hit_s;
    logic                res_take_s;

    // Handshake events derived from the decoded state outputs.
    always_comb begin
        req_take_s = req_valid && req_ready_s;
        capture_s  = rsp_valid && rsp_ready_s;
        res_take_s = res_valid_s && res_ready;
    end

    // Timeout fires on the last permitted ISSUE/WAIT cycle; a zero limit disables it.
    always_comb begin
        tmo_hit_s = 1'b0;
        if (TIMEOUT_CYCLES == 32'd0) begin
            tmo_hit_s = 1'b0;
        end else begin
            tmo_hit_s = is_active(state_r) && (tmo_cnt_r == (TIMEOUT_CYCLES - 32'd1));
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a captured response takes priority over a coincident timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (capture_s) begin
                    state_nxt_s = ST_DONE;
                end else if (tmo_hit_s) begin
                    state_nxt_s = ST_DONE;
                end else if (cmd_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (capture_s) begin
                    state_nxt_s = ST_DONE;
                end else if (tmo_hit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded purely from the current state.
    always_comb begin
        req_ready_s = 1'b0;
        cmd_valid_s = 1'b0;
        rsp_ready_s = 1'b0;
        res_valid_s = 1'b0;
        busy_s      = 1'b1;
        case (state_r)
            ST_IDLE: begin
                req_ready_s = 1'b1;
                busy_s      = 1'b0;
            end
            ST_ISSUE: begin
                cmd_valid_s = 1'b1;
                rsp_ready_s = 1'b1;
            end
            ST_WAIT: begin
                rsp_ready_s = 1'b1;
            end
            ST_DONE: begin
                res_valid_s = 1'b1;
            end
            default: begin
                busy_s = 1'b1;
            end
        endcase
    end

    // Payload registers: loaded only when a request is accepted, so they stay
    // constant for the whole time the command is offered to the CFU.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fid_r <= 3'b000;
            in0_r <= 32'h0000_0000;
            in1_r <= 32'h0000_0000;
        end else if (req_take_s) begin
            fid_r <= req_function_id;
            in0_r <= req_inputs_0;
            in1_r <= req_inputs_1;
        end else begin
            fid_r <= fid_r;
            in0_r <= in0_r;
            in1_r <= in1_r;
        end
    end

    // Timeout counter: cleared on ISSUE entry, counts every ISSUE/WAIT cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt_r <= 32'd0;
        end else if (req_take_s) begin
            tmo_cnt_r <= 32'd0;
        end else if (is_active(state_r)) begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Result registers: response capture wins over a coincident timeout abort.
    always_ff @(posedge clk) begin
        if (!reset) begin
            res_data_r    <= 32'h0000_0000;
            res_ok_r      <= 1'b0;
            res_timeout_r <= 1'b0;
        end else if (capture_s) begin
            res_data_r    <= rsp_payload_outputs_0;
            res_ok_r      <= rsp_payload_response_ok;
            res_timeout_r <= 1'b0;
        end else if (tmo_hit_s) begin
            res_data_r    <= 32'h0000_0000;
            res_ok_r      <= 1'b0;
            res_timeout_r <= 1'b1;
        end else begin
            res_data_r    <= res_data_r;
            res_ok_r      <= res_ok_r;
            res_timeout_r <= res_timeout_r;
        end
    end

    // Completed-operation counter, including timed-out operations; wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            done_count_r <= 16'h0000;
        end else if (res_take_s) begin
            done_count_r <= done_count_r + 16'h0001;
        end else begin
            done_count_r <= done_count_r;
        end
    end

    assign req_ready               = req_ready_s;
    assign cmd_valid               = cmd_valid_s;
    assign rsp_ready               = rsp_ready_s;
    assign res_valid               = res_valid_s;
    assign busy                    = busy_s;
    assign cmd_payload_function_id = fid_r;
    assign cmd_payload_inputs_0    = in0_r;
    assign cmd_payload_inputs_1    = in1_r;
    assign res_data                = res_data_r;
    assign res_ok                  = res_ok_r;
    assign res_timeout             = res_timeout_r;
    assign done_count              = done_count_r;

endmodule

// File: tb/tb_cfu_initiator.sv
// Self-checking bench for cfu_initiator: a combinational SIMD-MACC CFU model,
// a scripted CFU responder driven from a vector table and from random
// operations, and hand-written reset/latency sequences.
module tb_cfu_initiator;
    import cfu_initiator_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [2:0]  req_function_id;
    logic [31:0] req_inputs_0, req_inputs_1;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1;
    logic        rsp_valid, rsp_ready, rsp_payload_response_ok;
    logic [31:0] rsp_payload_outputs_0;
    logic        res_valid, res_ready, res_ok, res_timeout, busy;
    logic [31:0] res_data;
    logic [15:0] done_count;

    logic        comb_mode = 1'b0;
    logic        cmd_ready_drv = 1'b0, rsp_valid_drv = 1'b0, rsp_ok_drv = 1'b0;
    logic [31:0] rsp_data_drv = 32'd0;
    logic [31:0] cfu_offset = 32'd0, cfu_acc = 32'd0;

    int checks = 0;
    int failures = 0;
    int exp_done = 0;

    cfu_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_function_id(req_function_id),
        .req_inputs_0(req_inputs_0), .req_inputs_1(req_inputs_1),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_function_id(cmd_payload_function_id),
        .cmd_payload_inputs_0(cmd_payload_inputs_0), .cmd_payload_inputs_1(cmd_payload_inputs_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_payload_response_ok(rsp_payload_response_ok), .rsp_payload_outputs_0(rsp_payload_outputs_0),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ok(res_ok),
        .res_timeout(res_timeout), .busy(busy), .done_count(done_count)
    );

    always #5 clk = ~clk;

    // SIMD multiply-accumulate of four signed byte lanes: in0 * (in1 + offset).
    function automatic logic [31:0] macc4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] off);
        int sum;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            sum += int'($signed(a[8*i +: 8])) * (int'($signed(b[8*i +: 8])) + int'($signed(off)));
        end
        return 32'(sum);
    endfunction

    // Result the MACC CFU returns for a command given its current state.
    function automatic logic [31:0] cfu_eval(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] off, input logic [31:0] acc);
        case (f)
            CFU_SET_OFFSET: return a;
            CFU_SET_ACC:    return a;
            CFU_MACC4:      return acc + macc4(a, b, off);
            CFU_READ:       return acc;
            default:        return 32'd0;
        endcase
    endfunction

    // CFU side: combinational MACC model or the scripted responder.
    always_comb begin
        if (comb_mode) begin
            cmd_ready               = rsp_ready;
            rsp_valid               = cmd_valid;
            rsp_payload_response_ok = 1'b1;
            rsp_payload_outputs_0   = cfu_eval(cmd_payload_function_id, cmd_payload_inputs_0,
                                               cmd_payload_inputs_1, cfu_offset, cfu_acc);
        end else begin
            cmd_ready               = cmd_ready_drv;
            rsp_valid               = rsp_valid_drv;
            rsp_payload_response_ok = rsp_ok_drv;
            rsp_payload_outputs_0   = rsp_data_drv;
        end
    end

    // MACC CFU internal state update on each accepted command.
    always @(posedge clk) begin
        if (comb_mode && cmd_valid && cmd_ready) begin
            case (cmd_payload_function_id)
                CFU_SET_OFFSET: cfu_offset <= cmd_payload_inputs_0;
                CFU_SET_ACC:    cfu_acc    <= cmd_payload_inputs_0;
                CFU_MACC4:      cfu_acc    <= cfu_acc + macc4(cmd_payload_inputs_0, cmd_payload_inputs_1, cfu_offset);
                default:        cfu_acc    <= cfu_acc;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // One operation through the comb MACC CFU: 3 cycles with res_ready=1.
    task automatic comb_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_data, input string tag);
        logic cv1, rv1, cv2, rv2, cv3, rv3, rr3;
        logic [31:0] d;
        req_valid = 1'b1; req_function_id = f; req_inputs_0 = a; req_inputs_1 = b;
        @(negedge clk);
        cv1 = cmd_valid; rv1 = res_valid;
        req_valid = 1'b0;
        @(negedge clk);
        cv2 = cmd_valid; rv2 = res_valid; d = res_data;
        chk($sformatf("%s_ok", tag), 32'(res_ok), 32'd1);
        @(negedge clk);
        cv3 = cmd_valid; rv3 = res_valid; rr3 = req_ready;
        exp_done++;
        chk($sformatf("%s_timing", tag), 32'({cv1, rv1, cv2, rv2, cv3, rv3, rr3}), 32'b1001001);
        chk($sformatf("%s_data", tag), d, exp_data);
    endtask

    // One operation against the scripted responder: cmd_ready rises d1 cycles
    // into ISSUE, response pulses d2 cycles after the handshake, DONE held
    // with res_ready=0 for 'hold' cycles while junk responses are offered.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int d1, input int d2, input logic [31:0] rdata, input logic rok,
                         input int hold, input int e_at, input logic [31:0] e_data,
                         input logic e_ok, input logic e_to, input string tag);
        int k, done_at, cv_n, rr_n, bad_pay, bad_hold;
        k = d1 + 1 + d2; done_at = 0; cv_n = 0; rr_n = 0; bad_pay = 0; bad_hold = 0;
        res_ready = 1'b0; rsp_data_drv = rdata; rsp_ok_drv = rok;
        chk($sformatf("%s_req_ready", tag), 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_function_id = f; req_inputs_0 = a; req_inputs_1 = b;
        @(negedge clk);
        req_valid = 1'b0; req_function_id = ~f; req_inputs_0 = ~a; req_inputs_1 = ~b;
        for (int c = 1; c <= 20; c++) begin
            if (res_valid) begin
                done_at = c;
                break;
            end
            if (cmd_valid) begin
                cv_n++;
                if ({cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1} !== {f, a, b}) bad_pay++;
            end
            if (rsp_ready) rr_n++;
            cmd_ready_drv = (c >= d1 + 1);
            rsp_valid_drv = (c == k);
            @(negedge clk);
        end
        cmd_ready_drv = 1'b0; rsp_valid_drv = 1'b0;
        chk($sformatf("%s_done_cycle", tag), 32'(done_at), 32'(e_at));
        chk($sformatf("%s_cmd_valid_cycles", tag), 32'(cv_n), 32'((d1 + 1 <= TMO) ? d1 + 1 : TMO));
        chk($sformatf("%s_rsp_ready_cycles", tag), 32'(rr_n), 32'(e_at - 1));
        chk($sformatf("%s_payload_hold", tag), 32'(bad_pay), 32'd0);
        for (int h = 0; h < hold; h++) begin
            rsp_valid_drv = ($urandom_range(1, 0) == 1);
            rsp_data_drv  = $urandom;
            rsp_ok_drv    = ~rok;
            if (!res_valid || req_ready || rsp_ready || cmd_valid || !busy ||
                res_data !== e_data || res_ok !== e_ok || res_timeout !== e_to) bad_hold++;
            @(negedge clk);
        end
        rsp_valid_drv = 1'b0;
        chk($sformatf("%s_done_hold", tag), 32'(bad_hold), 32'd0);
        chk($sformatf("%s_res_data", tag), res_data, e_data);
        chk($sformatf("%s_flags", tag), 32'({res_valid, res_ok, res_timeout}), 32'({1'b1, e_ok, e_to}));
        res_ready = 1'b1;
        @(negedge clk);
        exp_done++;
        chk($sformatf("%s_release", tag), 32'({res_valid, req_ready, busy}), 32'b010);
        chk($sformatf("%s_done_count", tag), 32'(done_count), 32'(exp_done[15:0]));
    endtask

    typedef struct {
        logic [2:0]  fid;
        logic [31:0] in0, in1;
        int          d1, d2;
        logic [31:0] rdata;
        logic        rok;
        int          hold;
        int          e_at;
        logic [31:0] e_data;
        logic        e_ok, e_to;
    } vec_t;

    vec_t vt[7];

    initial begin
        int d1, d2, k, e_at, hold;
        logic [31:0] rdata, e_data;
        logic rok, e_ok, e_to;

        vt[0] = '{3'd1, 32'h1111_1111, 32'h2222_2222, 0,  0, 32'h0BAD_F00D, 1'b1, 0, 2, 32'h0BAD_F00D, 1'b1, 1'b0};
        vt[1] = '{3'd2, 32'h0000_0003, 32'h0000_0004, 0,  3, 32'hDEAD_BEEF, 1'b0, 0, 5, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vt[2] = '{3'd3, 32'hCAFE_0000, 32'h0000_BABE, 2,  1, 32'h1234_5678, 1'b1, 5, 5, 32'h1234_5678, 1'b1, 1'b0};
        vt[3] = '{3'd0, 32'h8000_0001, 32'h7FFF_FFFE, 7,  0, 32'hA5A5_A5A5, 1'b1, 1, 9, 32'hA5A5_A5A5, 1'b1, 1'b0};
        vt[4] = '{3'd5, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 3,  5, 32'hFFFF_FFFF, 1'b1, 2, 9, 32'h0000_0000, 1'b0, 1'b1};
        vt[5] = '{3'd7, 32'h0000_0000, 32'hFFFF_FFFF, 12, 0, 32'h5555_AAAA, 1'b1, 0, 9, 32'h0000_0000, 1'b0, 1'b1};
        vt[6] = '{3'd4, 32'h1357_9BDF, 32'h2468_ACE0, 5,  2, 32'h00C0_FFEE, 1'b0, 3, 9, 32'h00C0_FFEE, 1'b0, 1'b0};

        reset = 1'b0; req_valid = 1'b0; req_function_id = 3'd0;
        req_inputs_0 = 32'd0; req_inputs_1 = 32'd0; res_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_ctrl", 32'({cmd_valid, rsp_ready, res_valid, res_ok, res_timeout, busy, req_ready}), 32'b0000001);
        chk("reset_res_data", res_data, 32'd0);
        chk("reset_done_count", 32'(done_count), 32'd0);
        chk("reset_payload", cmd_payload_inputs_0 | cmd_payload_inputs_1 | 32'(cmd_payload_function_id), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Combinational SIMD-MACC CFU: 3-cycle operations.
        comb_mode = 1'b1;
        comb_op(CFU_SET_OFFSET, 32'd128,        32'd0, 32'd128, "macc_set_offset");
        comb_op(CFU_SET_ACC,    32'd0,          32'd0, 32'd0,   "macc_set_acc");
        comb_op(CFU_MACC4,      32'h0101_0101,  32'd0, 32'd512, "macc_macc4");
        comb_op(CFU_READ,       32'd0,          32'd0, 32'd512, "macc_read");
        chk("macc_done_count", 32'(done_count), 32'd4);
        comb_mode = 1'b0;
        @(negedge clk);

        // Vector table against the scripted responder.
        for (int i = 0; i < 7; i++) begin
            do_op(vt[i].fid, vt[i].in0, vt[i].in1, vt[i].d1, vt[i].d2, vt[i].rdata, vt[i].rok,
                  vt[i].hold, vt[i].e_at, vt[i].e_data, vt[i].e_ok, vt[i].e_to, $sformatf("vec%0d", i));
        end

        // Random operations against a cycle-count reference model.
        for (int n = 0; n < 40; n++) begin
            d1 = $urandom_range(9, 0);
            d2 = $urandom_range(5, 0);
            hold = $urandom_range(2, 0);
            rdata = $urandom;
            rok = ($urandom_range(1, 0) == 1);
            k = d1 + 1 + d2;
            if (k <= TMO) begin
                e_at = k + 1; e_data = rdata; e_ok = rok; e_to = 1'b0;
            end else begin
                e_at = TMO + 1; e_data = 32'd0; e_ok = 1'b0; e_to = 1'b1;
            end
            do_op(3'($urandom_range(7, 0)), $urandom, $urandom, d1, d2, rdata, rok, hold,
                  e_at, e_data, e_ok, e_to, $sformatf("rnd%0d", n));
        end

        // Reset during WAIT abandons the command; a late response is ignored.
        res_ready = 1'b1;
        req_valid = 1'b1; req_function_id = CFU_MACC4; req_inputs_0 = 32'h7777_7777; req_inputs_1 = 32'h3;
        rsp_data_drv = 32'h9999_9999; rsp_ok_drv = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; cmd_ready_drv = 1'b1;
        @(negedge clk);
        cmd_ready_drv = 1'b0;
        chk("wait_state", 32'({busy, cmd_valid, rsp_ready, res_valid}), 32'b1010);
        reset = 1'b0;
        @(negedge clk);
        exp_done = 0;
        chk("midreset_ctrl", 32'({cmd_valid, rsp_ready, res_valid, res_ok, res_timeout, busy, req_ready}), 32'b0000001);
        chk("midreset_res_data", res_data, 32'd0);
        chk("midreset_done_count", 32'(done_count), 32'd0);
        chk("midreset_payload", cmd_payload_inputs_0 | cmd_payload_inputs_1 | 32'(cmd_payload_function_id), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        rsp_valid_drv = 1'b1;
        @(negedge clk);
        rsp_valid_drv = 1'b0;
        chk("late_rsp_ignored", 32'({res_valid, busy, rsp_ready}), 32'b000);
        chk("late_rsp_data", res_data, 32'd0);
        @(negedge clk);
        chk("late_rsp_idle", 32'({res_valid, req_ready, done_count}), 32'({1'b0, 1'b1, 16'h0000}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
